// File: rtl/uart_pkt_rx_pkg.sv
// Shared definitions for the UART packet receiver: FSM state encoding and
// default line-rate constants (65 MHz system clock, 9600 baud).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE_WAIT,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP,
        GAP,
        DONE
    } state_t;

    localparam int CLK_HZ    = 65_000_000;
    localparam int BAUD_RATE = 9600;

    // Rounded to the nearest whole clock.
    localparam int CLK_PER_BIT = (CLK_HZ + BAUD_RATE / 2) / BAUD_RATE;

endpackage

// File: rtl/uart_pkt_rx_sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial pin; resets to the
// line's idle level (1) so no false falling edge appears out of reset.
module sync_2ff (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_pkt_rx.sv
// UART packet receiver: idle qualification, mid-bit deframing of NUM_BYTES
// characters into one packet word. Define UART_PKT_RX_PARITY_EN for even parity.
module uart_pkt_rx #(
    parameter int CLK_PER_BIT = uart_pkg::CLK_PER_BIT,
    parameter int DATA_BITS   = 8,
    parameter int NUM_BYTES   = 21,
    parameter int IDLE_CLKS   = 130_000
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           sig_in,
    output logic [NUM_BYTES*DATA_BITS-1:0] data_out,
    output logic                           valid_out,
    output logic                           frame_err_out,
    output logic                           busy_out
);

    import uart_pkg::*;

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int IW = $clog2(IDLE_CLKS);
    localparam int BW = $clog2(NUM_BYTES) + 1;
    localparam int XW = $clog2(DATA_BITS) + 1;
    localparam int PW = NUM_BYTES * DATA_BITS;

    localparam logic [CW-1:0] BIT_FULL  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF  = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CLKS - 1);
    localparam logic [BW-1:0] BYTE_LAST = BW'(NUM_BYTES - 1);
    localparam logic [XW-1:0] BIT_LAST  = XW'(DATA_BITS - 1);

    logic sig_s;
    logic sig_s_q;
    logic fall;
    logic bit_zero;

    state_t               state_q, state_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic [BW-1:0]        byte_idx_q, byte_idx_d;
    logic [XW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] char_q, char_d;
    logic [PW-1:0]        pkt_q, pkt_d;
    logic [PW-1:0]        data_d;
    logic                 valid_d;
    logic                 err_d;

    sync_2ff u_sync (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d        (sig_in),
        .q        (sig_s)
    );

    assign fall     = sig_s_q & ~sig_s;
    assign bit_zero = (bit_cnt_q == '0);
    assign busy_out = (state_q != IDLE_WAIT) && (state_q != ARMED);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        char_d     = char_q;
        pkt_d      = pkt_q;
        data_d     = data_out;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            // A low sample here does not block the transition; ARMED must
            // then see the line high before it accepts a start edge.
            IDLE_WAIT: begin
                if (idle_cnt_q == IDLE_LAST) begin
                    idle_cnt_d = '0;
                    state_d    = ARMED;
                end else if (!sig_s) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end

            ARMED: begin
                if (fall) begin
                    bit_cnt_d  = BIT_HALF;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    state_d    = START;
                end
            end

            START: begin
                if (bit_zero) begin
                    if (!sig_s) begin
                        bit_cnt_d = BIT_FULL;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = ARMED;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

            DATA: begin
                if (bit_zero) begin
                    char_d    = {sig_s, char_q[DATA_BITS-1:1]};
                    bit_cnt_d = BIT_FULL;
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_PKT_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

`ifdef UART_PKT_RX_PARITY_EN
            // Even parity: data bits plus parity bit hold an even number of ones.
            PARITY: begin
                if (bit_zero) begin
                    if (^{char_q, sig_s} == 1'b0) begin
                        bit_cnt_d = BIT_FULL;
                        state_d   = STOP;
                    end else begin
                        err_d      = 1'b1;
                        idle_cnt_d = '0;
                        state_d    = IDLE_WAIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
`endif

            STOP: begin
                if (bit_zero) begin
                    if (sig_s) begin
                        pkt_d[int'(byte_idx_q)*DATA_BITS +: DATA_BITS] = char_q;
                        if (byte_idx_q == BYTE_LAST) begin
                            state_d = DONE;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                            idle_cnt_d = '0;
                            state_d    = GAP;
                        end
                    end else begin
                        err_d      = 1'b1;
                        idle_cnt_d = '0;
                        state_d    = IDLE_WAIT;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

            // Inter-character gap; too long a silence means a truncated packet.
            GAP: begin
                if (fall) begin
                    bit_cnt_d = BIT_HALF;
                    state_d   = START;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    err_d      = 1'b1;
                    idle_cnt_d = '0;
                    state_d    = IDLE_WAIT;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end

            DONE: begin
                data_d     = pkt_q;
                valid_d    = 1'b1;
                idle_cnt_d = '0;
                state_d    = IDLE_WAIT;
            end

            default: begin
                idle_cnt_d = '0;
                state_d    = IDLE_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= IDLE_WAIT;
            sig_s_q       <= 1'b1;
            bit_cnt_q     <= '0;
            idle_cnt_q    <= '0;
            byte_idx_q    <= '0;
            bit_idx_q     <= '0;
            char_q        <= '0;
            pkt_q         <= '0;
            data_out      <= '0;
            valid_out     <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            state_q       <= state_d;
            sig_s_q       <= sig_s;
            bit_cnt_q     <= bit_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            byte_idx_q    <= byte_idx_d;
            bit_idx_q     <= bit_idx_d;
            char_q        <= char_d;
            pkt_q         <= pkt_d;
            data_out      <= data_d;
            valid_out     <= valid_d;
            frame_err_out <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Directed bench for uart_pkt_rx: stimulus queues the expected strobes, an
// independent monitor pops and compares them whenever the DUT strobes.
module tb_uart_pkt_rx;

    localparam int CPB = 16;
    localparam int NB  = 2;
    localparam int IC  = 64;
    localparam int DB  = 8;

    logic            clk_in   = 1'b0;
    logic            rst_n_in = 1'b0;
    logic            sig_in   = 1'b1;
    logic [NB*DB-1:0] data_out;
    logic            valid_out;
    logic            frame_err_out;
    logic            busy_out;

    typedef struct packed {
        logic            is_err;
        logic [NB*DB-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
`ifdef UART_PKT_RX_PARITY_EN
    logic bad_par = 1'b0;
`endif

    uart_pkt_rx #(
        .CLK_PER_BIT (CPB),
        .DATA_BITS   (DB),
        .NUM_BYTES   (NB),
        .IDLE_CLKS   (IC)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .sig_in        (sig_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .frame_err_out (frame_err_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive a level for a number of clocks, changing on the falling edge.
    task automatic applyStimulus(input logic level, input int clocks);
        sig_in = level;
        repeat (clocks) @(negedge clk_in);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic stop_bit);
        applyStimulus(1'b0, CPB);
        for (int i = 0; i < DB; i++) applyStimulus(b[i], CPB);
`ifdef UART_PKT_RX_PARITY_EN
        applyStimulus((^b) ^ bad_par, CPB);
`endif
        applyStimulus(stop_bit, CPB);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 4000) begin
            @(negedge clk_in);
            n++;
        end
        checkOutput({"drain_", name}, 32'(sb.size()), 32'd0);
    endtask

    task automatic monitorLoop();
        exp_t item;
        forever begin
            @(negedge clk_in);
            if (rst_n_in && (valid_out || frame_err_out)) begin
                checkOutput("strobe_exclusive", {31'b0, valid_out & frame_err_out}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_strobe: got valid=%b err=%b, expected none at %0t",
                             valid_out, frame_err_out, $time);
                end else begin
                    item = sb.pop_front();
                    checkOutput("strobe_kind", {30'b0, valid_out, frame_err_out},
                                item.is_err ? 32'd1 : 32'd2);
                    checkOutput("data_out", 32'(data_out), 32'(item.data));
                end
            end
        end
    endtask

    initial begin
        fork
            monitorLoop();
        join_none

        repeat (3) @(negedge clk_in);
        checkOutput("reset_data", 32'(data_out), 32'd0);
        checkOutput("reset_valid", 32'(valid_out), 32'd0);
        checkOutput("reset_err", 32'(frame_err_out), 32'd0);
        checkOutput("reset_busy", 32'(busy_out), 32'd0);
        rst_n_in = 1'b1;

        $display("[TB] good packet A5 3C");
        applyStimulus(1'b1, 80);
        sb.push_back({1'b0, 16'h3CA5});
        sendByte(8'hA5, 1'b1);
        sendByte(8'h3C, 1'b1);
        applyStimulus(1'b1, 16);
        waitDrain("good_pkt");

        $display("[TB] stop-bit error on second character");
        applyStimulus(1'b1, 80);
        sb.push_back({1'b1, 16'h3CA5});
        sendByte(8'hA5, 1'b1);
        sendByte(8'h3C, 1'b0);
        applyStimulus(1'b1, 16);
        waitDrain("stop_err");
        checkOutput("idle_after_stop_err", 32'(busy_out), 32'd0);

        $display("[TB] glitch then packet 01 02");
        applyStimulus(1'b1, 80);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 32);
        checkOutput("armed_after_glitch", 32'(busy_out), 32'd0);
        sb.push_back({1'b0, 16'h0201});
        sendByte(8'h01, 1'b1);
        sendByte(8'h02, 1'b1);
        applyStimulus(1'b1, 16);
        waitDrain("glitch_pkt");

        $display("[TB] truncated packet then FF 00");
        applyStimulus(1'b1, 80);
        sb.push_back({1'b1, 16'h0201});
        sendByte(8'h55, 1'b1);
        applyStimulus(1'b1, 70);
        waitDrain("truncated");
        applyStimulus(1'b1, 80);
        sb.push_back({1'b0, 16'h00FF});
        sendByte(8'hFF, 1'b1);
        sendByte(8'h00, 1'b1);
        applyStimulus(1'b1, 16);
        waitDrain("after_trunc");

        $display("[TB] reset during data bits");
        applyStimulus(1'b1, 80);
        applyStimulus(1'b0, CPB);
        applyStimulus(1'b0, CPB);
        applyStimulus(1'b1, CPB);
        applyStimulus(1'b0, CPB / 2);
        checkOutput("busy_mid_char", 32'(busy_out), 32'd1);
        rst_n_in = 1'b0;
        #1;
        checkOutput("mid_reset_data", 32'(data_out), 32'd0);
        checkOutput("mid_reset_valid", 32'(valid_out), 32'd0);
        checkOutput("mid_reset_err", 32'(frame_err_out), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy_out), 32'd0);
        repeat (2) @(negedge clk_in);
        sig_in   = 1'b1;
        rst_n_in = 1'b1;
        applyStimulus(1'b1, 80);
        sb.push_back({1'b0, 16'h3412});
        sendByte(8'h12, 1'b1);
        sendByte(8'h34, 1'b1);
        applyStimulus(1'b1, 16);
        waitDrain("after_reset");

`ifdef UART_PKT_RX_PARITY_EN
        $display("[TB] parity error then good parity");
        applyStimulus(1'b1, 80);
        bad_par = 1'b1;
        sb.push_back({1'b1, 16'h3412});
        sendByte(8'h07, 1'b1);
        bad_par = 1'b0;
        applyStimulus(1'b1, 16);
        waitDrain("parity_err");
        applyStimulus(1'b1, 80);
        sb.push_back({1'b0, 16'h0007});
        sendByte(8'h07, 1'b1);
        sendByte(8'h00, 1'b1);
        applyStimulus(1'b1, 16);
        waitDrain("parity_ok");
`endif

        applyStimulus(1'b1, 40);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_pkt_rx.md
# uart_pkt_rx

Parametrised UART packet receiver that turns a serial line into one wide, byte-aligned packet word. It qualifies the line as idle, then deframes NUM_BYTES consecutive 8N1 characters (start, DATA_BITS LSB-first, stop) with mid-bit sampling. It checks start and stop bits per character and aborts truncated packets. It sits between the board-level serial pin and the game-state decoder, and presents each complete packet with a one-cycle valid strobe.

## Interface
- CLK_PER_BIT, 6771: clocks per bit period (65 MHz / 9600 baud); must be ≥ 4.
- DATA_BITS, 8: data bits per character.
- NUM_BYTES, 21: characters per packet.
- IDLE_CLKS, 130_000: consecutive high clocks that qualify the line idle (2 ms at 65 MHz).
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- sig_in  input  1  raw serial line; idles high.
- data_out  output  NUM_BYTES*DATA_BITS  last good packet; character 0 in bits [DATA_BITS-1:0].
- valid_out  output  1  one-cycle strobe when data_out updates.
- frame_err_out  output  1  one-cycle strobe when a packet is dropped.
- busy_out  output  1  high in any state other than IDLE_WAIT and ARMED.

## Operation
- sig_in passes through a 2-flop synchroniser (sig_s) before any use. A falling edge is sig_s_q & ~sig_s.
- IDLE_WAIT: the counter clears when sig_s=0 and increments otherwise. When the counter reaches IDLE_CLKS-1, the block moves to ARMED.
- ARMED: on a falling edge, the block loads the counter with CLK_PER_BIT/2-1, clears the byte and bit indices, and moves to START.
- START: at count 0, if sig_s=0, reload the counter with CLK_PER_BIT-1 and move to DATA. If sig_s=1, this is a glitch: return to ARMED with no error.
- DATA: at each count 0, shift sig_s into the character register at the MSB (LSB-first arrival) and reload the counter. After DATA_BITS samples, move to the parity state or to STOP.
- STOP: at count 0, sig_s=1 is required. On success, write the character into the packet register at slot byte_idx.
  - If byte_idx = NUM_BYTES-1, move to DONE.
  - Otherwise, increment byte_idx, clear the gap counter, and move to GAP.
  - If sig_s=0, this is a framing error: strobe frame_err_out and move to IDLE_WAIT.
- GAP: a falling edge moves the block to START, with the counter reloaded to CLK_PER_BIT/2-1. If the gap counter reaches IDLE_CLKS-1 first, the packet is truncated: strobe frame_err_out and move to IDLE_WAIT.
- DONE: copy the packet register to data_out, pulse valid_out, and move to IDLE_WAIT.
- Dropped packets never modify data_out. Partial data stays in the internal packet register only.
- Counters: bit counter is $clog2(CLK_PER_BIT) bits; idle/gap counter is $clog2(IDLE_CLKS) bits; byte index is $clog2(NUM_BYTES)+1 bits. No wrap is reachable, because every count terminates at its compare value.

## Timing
- Reset values: data_out=0, valid_out=0, frame_err_out=0, busy_out=0, state=IDLE_WAIT, synchroniser flops=1.
- Reset asserted mid-packet aborts immediately, with no strobe on any output.
- Sample point is the bit centre, measured from the synchronised falling edge. The fixed offset is 2 clocks of synchroniser delay.
- valid_out rises 2 clocks after the last stop-bit sample: STOP→DONE takes 1 clock, and the data_out/valid_out registers take 1 more.
- valid_out and frame_err_out are never high in the same cycle, and each is exactly one clock wide.
- A falling edge in the same cycle that IDLE_WAIT completes is ignored. The line must be seen idle in ARMED first.

## Configuration
- UART_PKT_RX_PARITY_EN defined:
  - Each character carries an even-parity bit after the data bits, sampled in a PARITY state.
  - A mismatch is treated like a stop-bit failure: frame_err_out is strobed and the block returns to IDLE_WAIT.
- UART_PKT_RX_PARITY_EN undefined: the PARITY state and its logic are absent, and the format is 8N1.

## Structure
- Package uart_pkg holds:
  - the state enum typedef (IDLE_WAIT, ARMED, START, DATA, PARITY, STOP, GAP, DONE);
  - default constants CLK_HZ, BAUD_RATE, and the derived CLK_PER_BIT.
- Sub-module sync_2ff (1-bit, reset value 1) implements the input synchroniser. Everything else lives in one FSM module.

## Test plan
Simulation parameters: CLK_PER_BIT=16, NUM_BYTES=2, IDLE_CLKS=64.
- 80 clocks high, then bytes 0xA5, 0x3C sent back-to-back → data_out=16'h3CA5, one valid_out pulse, frame_err_out never asserted.
- Same as above, but the second character's stop bit is driven 0 → frame_err_out pulses once, data_out unchanged, state returns to IDLE_WAIT.
- Line held high for 80 clocks, then a 3-clock low glitch, then the valid packet 0x01, 0x02 → glitch ignored, data_out=16'h0201.
- One good byte, then the line held high for 70 clocks → frame_err_out pulses, no valid_out; the next packet 0xFF, 0x00 decodes to 16'h00FF.
- rst_n_in pulsed low during the first character's data bits → all outputs 0 at once; a following full packet decodes correctly.
- With UART_PKT_RX_PARITY_EN defined, 0x07 sent with parity bit 0 → frame_err_out; the same byte with parity bit 1 is accepted.
